// File: rtl/regfile_onehot_wr.sv
// 32-entry general-purpose register file.
// The write port takes a one-hot select from an upstream address decoder.
// There are two registered read ports, and register 0 always reads as zero.
// A malformed select while we=1 suppresses the write.
// It also sets a sticky error flag, which err_clr clears.
module regfile_onehot_wr #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [31:0]       wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              err_clr,
    output logic              onehot_err,
    output logic [15:0]       wr_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ERR  = 1'b1
    } mon_state_t;

    mon_state_t        state;
    logic [DATA_W-1:0] regs [32];

    logic wsel_ok;
    logic wr_valid;
    logic wr_invalid;
    logic commit;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
    assign wsel_ok    = (wsel != 32'd0) && ((wsel & (wsel - 32'd1)) == 32'd0);
    assign wr_valid   = we && wsel_ok;
    assign wr_invalid = we && !wsel_ok;
    // A select of register 0 is legal but discarded, so it is not a commit.
    assign commit     = wr_valid && !wsel[0];

    // Read-port value for one address.
    // Register 0 reads as zero, and a same-edge commit is forwarded when BYPASS=1.
    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] ra);
        logic [DATA_W-1:0] val;
        if (ra == 5'd0) begin
            val = '0;
        end else if (BYPASS && commit && wsel[ra]) begin
            val = wdata;
        end else begin
            val = regs[ra];
        end
        return val;
    endfunction

    // Register storage: each row is written directly from its one-hot select bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset here because every register must read as zero right after reset.
            // A RAM macro would not allow that, so this file maps to flops.
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            // Every reader in this file then sees the pre-edge value.
            regs[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (wr_valid && wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Registered read ports, one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= read_port(ra1);
            rd2 <= read_port(ra2);
        end
    end

    // Count of committed writes; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= 16'd0;
        end else if (commit) begin
            wr_cnt <= wr_cnt + 16'd1;
        end
    end

    // Write-port monitor: IDLE/ERR.
    // A set on the same edge as err_clr wins, so ERR stays.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            onehot_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_invalid) begin
                        state      <= ERR;
                        onehot_err <= 1'b1;
                    end
                end
                ERR: begin
                    if (err_clr && !wr_invalid) begin
                        state      <= IDLE;
                        onehot_err <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    onehot_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Randomised scoreboard bench for regfile_onehot_wr.
// The stimulus drives inputs on the falling edge.
// At the same time it queues the response expected after the next rising edge.
// The monitor pops and compares that response just after the rising edge.
module tb_regfile_onehot_wr;

    localparam bit BYPASS = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] wsel;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err_clr;
    logic        onehot_err;
    logic [15:0] wr_cnt;

    regfile_onehot_wr #(.DATA_W(32), .BYPASS(BYPASS)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wsel       (wsel),
        .wdata      (wdata),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .err_clr    (err_clr),
        .onehot_err (onehot_err),
        .wr_cnt     (wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the architectural view of the register file.
    logic [31:0] mem [32];
    logic        m_err;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        m_err = 1'b0;
        m_cnt = 16'd0;
    endtask

    // One clock of stimulus.
    // The model computes the post-edge outputs from the pre-edge state and queues them.
    task automatic do_cycle(input logic w, input logic [31:0] sel, input logic [31:0] d,
                            input logic [4:0] a1, input logic [4:0] a2, input logic clr);
        exp_t e;
        int   idx;
        bit   valid;
        bit   committed;
        @(negedge clk);
        we = w; wsel = sel; wdata = d; ra1 = a1; ra2 = a2; err_clr = clr;
        valid = w && ($countones(sel) == 1);
        idx = -1;
        for (int i = 0; i < 32; i++) if (sel[i]) idx = i;
        committed = valid && (idx != 0);
        e.rd1 = (a1 == 0) ? 32'd0 : (BYPASS && committed && idx == int'(a1)) ? d : mem[a1];
        e.rd2 = (a2 == 0) ? 32'd0 : (BYPASS && committed && idx == int'(a2)) ? d : mem[a2];
        if (w && !valid) m_err = 1'b1;
        else if (clr)    m_err = 1'b0;
        if (committed) begin
            mem[idx] = d;
            m_cnt    = m_cnt + 16'd1;
        end
        e.err = m_err;
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    // Reset asserted mid-cycle while a valid write is on the inputs.
    // The write must not commit, and the outputs must clear at once.
    task automatic mid_reset();
        @(negedge clk);
        we = 1'b1; wsel = 32'h0000_0080; wdata = 32'hA5A5_A5A5; ra1 = 5'd5; ra2 = 5'd10; err_clr = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_rd1", rd1, 32'd0);
        check("async_rst_rd2", rd2, 32'd0);
        check("async_rst_err", {31'd0, onehot_err}, 32'd0);
        check("async_rst_cnt", {16'd0, wr_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        we = 1'b0;
        reset = 1'b0;
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rd1", rd1, e.rd1);
                check("rd2", rd2, e.rd2);
                check("onehot_err", {31'd0, onehot_err}, {31'd0, e.err});
                check("wr_cnt", {16'd0, wr_cnt}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        logic [31:0] sel;
        logic [31:0] d;
        int          r;
        int          guard;

        reset = 1'b1; we = 1'b0; wsel = '0; wdata = '0; ra1 = '0; ra2 = '0; err_clr = 1'b0;
        model_reset();
        #1;
        check("por_rd1", rd1, 32'd0);
        check("por_err", {31'd0, onehot_err}, 32'd0);
        check("por_cnt", {16'd0, wr_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Write reg 5, then read it back.
        do_cycle(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
        do_cycle(1'b0, 32'h0,         32'h0,         5'd5, 5'd10, 1'b0);
        // Same-edge write to reg 10 with ra2=10 exercises forwarding.
        do_cycle(1'b1, 32'h0000_0400, 32'h1234_5678, 5'd5, 5'd10, 1'b0);
        do_cycle(1'b0, 32'h0,         32'h0,         5'd10, 5'd10, 1'b0);
        // A write to reg 0 is discarded.
        do_cycle(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0);
        do_cycle(1'b0, 32'h0,         32'h0,         5'd0, 5'd1, 1'b0);
        // Malformed selects, the sticky flag and clear priority.
        do_cycle(1'b1, 32'h0000_0003, 32'hCAFE_F00D, 5'd0, 5'd1, 1'b0);
        do_cycle(1'b0, 32'h0,         32'h0,         5'd0, 5'd1, 1'b0);
        do_cycle(1'b1, 32'h0,         32'h1111_1111, 5'd0, 5'd1, 1'b0);
        do_cycle(1'b0, 32'h0,         32'h0,         5'd5, 5'd1, 1'b1);
        do_cycle(1'b1, 32'h8000_8000, 32'h2222_2222, 5'd15, 5'd31, 1'b1);
        do_cycle(1'b0, 32'h0,         32'h0,         5'd15, 5'd31, 1'b0);
        do_cycle(1'b0, 32'hFFFF_FFFF, 32'h3333_3333, 5'd5, 5'd10, 1'b1);
        do_cycle(1'b0, 32'hFFFF_FFFF, 32'h4444_4444, 5'd5, 5'd10, 1'b0);

        // Reset mid-stream, then read reg 5 and the aborted reg 7 target.
        do_cycle(1'b1, 32'h0000_0020, 32'h5555_5555, 5'd5, 5'd0, 1'b0);
        mid_reset();
        do_cycle(1'b0, 32'h0, 32'h0, 5'd5, 5'd7, 1'b0);

        // Randomised traffic: mostly one-hot selects, plus zero and arbitrary patterns.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      sel = 32'd1 << $urandom_range(0, 31);
            else if (r < 75) sel = 32'd0;
            else             sel = $urandom();
            d = $urandom();
            do_cycle(($urandom_range(0, 3) != 0), sel, d, 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), ($urandom_range(0, 9) == 0));
        end

        // Counter wrap: from reset, 65536 committed writes return wr_cnt to zero.
        mid_reset();
        for (int n = 0; n < 65536; n++) begin
            do_cycle(1'b1, 32'h8000_0000, $urandom(), 5'd31, 5'd31, 1'b0);
        end
        do_cycle(1'b0, 32'h0, 32'h0, 5'd31, 5'd31, 1'b0);

        // Drain the scoreboard within a bounded number of edges.
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        check("final_cnt_wrapped", {16'd0, wr_cnt}, 32'd0);
        check("final_ports_equal", rd1, rd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32 x 32-bit general-purpose register file, placed directly downstream of the 5-to-32 write-address decoder.
- Accepts the decoder's one-hot write-select vector as its write port and provides two registered read ports.
- Register 0 is hardwired to zero.
- Guards against malformed select vectors with a sticky error flag and write suppression.

Parameters:
- DATA_W, 32, register width in bits.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read; when 0 the read returns the pre-write value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- wsel  input  32  one-hot write select, driven by the decoder; bit i selects register i.
- wdata  input  DATA_W  write data.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  DATA_W  registered read data, port 1.
- rd2  output  DATA_W  registered read data, port 2.
- err_clr  input  1  synchronous clear of onehot_err.
- onehot_err  output  1  sticky flag for an invalid wsel seen while we=1.
- wr_cnt  output  16  count of committed writes; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, active-high; reset is asynchronous and active-high, one clock domain):
  - All 32 registers, rd1, rd2, onehot_err and wr_cnt clear to 0 immediately.
  - Reset asserted mid-operation aborts any in-flight write; nothing commits on that edge.
- Write validity: wsel_ok = popcount(wsel)==1.
- Commit: on a rising edge with we=1 and wsel_ok, register i takes wdata, where wsel[i]=1.
  - If i==0 the write is discarded: register 0 stays 0 and wr_cnt does not increment.
  - Otherwise wr_cnt increments by 1.
- Invalid write: we=1 with wsel zero or multi-hot.
  - No register changes and wr_cnt is unchanged.
  - onehot_err is set to 1 on that edge.
- we=0: wsel is ignored, including malformed values; there are no side effects.
- Error flag: onehot_err stays at 1 until err_clr=1 at a clock edge.
  - If err_clr and a new invalid write occur on the same edge, the set wins and onehot_err stays 1.
- Read latency: 1 cycle. On each edge, rdN takes the value of register raN.
  - raN==0 always yields 0.
  - BYPASS=1: if a valid commit targets raN (raN!=0) on the same edge, rdN takes wdata.
  - BYPASS=0: rdN takes the register's old contents.
  - Both ports may read the same address; both return identical data.
- wr_cnt wraps from 0xFFFF to 0x0000 on the next committed write; no saturation.
- Internal phase state: a 2-state write-port monitor, IDLE/ERR, mirrors onehot_err.
  - IDLE -> ERR on an invalid write.
  - ERR -> IDLE on err_clr with no new invalid write.
  - ERR persists otherwise.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Assert reset mid-stream after several writes -> regs, rd1, rd2, wr_cnt and onehot_err all 0 immediately. Then read ra1=5 -> rd1=0 after one edge.
2. we=1, wsel=32'h0000_0020, wdata=32'hDEAD_BEEF; next cycle ra1=5 -> rd1=32'hDEAD_BEEF one cycle later; wr_cnt=1.
3. BYPASS=1: same-edge write wsel=32'h0000_0400 (reg 10), wdata=32'h1234_5678 with ra2=10 -> rd2=32'h1234_5678 after that edge. BYPASS=0 build -> rd2 holds the old value, 0.
4. we=1, wsel=32'h0000_0001, wdata=32'hFFFF_FFFF -> reading ra1=0 gives 0; wr_cnt unchanged.
5. we=1, wsel=32'h0000_0003 -> onehot_err=1, regs 0 and 1 unchanged, wr_cnt unchanged. we=1, wsel=0 -> onehot_err=1. err_clr alone -> 0. err_clr together with wsel=32'h8000_8000, we=1 -> stays 1. we=0 with wsel=32'hFFFF_FFFF -> no change.
6. 65 536 valid writes to reg 31 -> wr_cnt wraps to 0x0000. Reg 31 holds the last wdata, and ra1=ra2=31 give equal outputs.
